// File: rtl/axi_pkg.sv
// Shared AXI read-channel encodings, widths and the beat record carried through the R buffer.
package axi_pkg;

    localparam int AXI_DATA_W = 64;
    localparam int AXI_ADDR_W = 32;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } rbeat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } rd_state_e;

endpackage

// File: rtl/axi_rd_skid_fifo.sv
// Two-entry FIFO of R beats that absorbs rready backpressure; occupancy is exported for issue throttling.
module axi_rd_skid_fifo
    import axi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  rbeat_t     din,
    input  logic       pop,
    output rbeat_t     dout,
    output logic [1:0] count
);

    rbeat_t entry [2];
    logic   wr_ptr;
    logic   rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry[0] <= '0;
            entry[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= din;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout = entry[rd_ptr];

endmodule

// File: rtl/axi_burst_rd_slave.sv
// AXI4 AR/R responder serving one burst at a time from a 1-cycle-latency 64-bit memory port.
module axi_burst_rd_slave
    import axi_pkg::*;
#(
    parameter logic [AXI_ADDR_W-1:0] MEM_BASE       = 32'h8000_0000,
    parameter logic [AXI_ADDR_W-1:0] MEM_BYTES      = 32'h0800_0000,
    parameter bit                    ARLEN_IS_COUNT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXI_ADDR_W-1:0] araddr,
    input  logic                  arvalid,
    input  logic [1:0]            arburst,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    output logic                  arready,
    output logic [AXI_DATA_W-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    output logic                  rlast,
    input  logic                  rready,
    output logic                  mem_en,
    output logic [AXI_ADDR_W-1:0] mem_addr,
    input  logic [AXI_DATA_W-1:0] mem_rdata
);

    rd_state_e             state_q, state_d;
    logic                  arready_q;
    logic [AXI_ADDR_W-1:0] addr_q;
    logic [1:0]            mode_q;
    logic [2:0]            size_q;
    logic [8:0]            beats_q;
    logic                  slverr_q;
    logic [8:0]            issue_left_q;
    logic                  pend_vld_q;
    logic [1:0]            pend_resp_q;
    logic                  pend_last_q;

    logic [8:0]            beats_req;
    logic                  bad_req;
    logic                  ar_hs;
    logic                  issue;
    logic                  in_range;
    logic [1:0]            beat_resp;
    logic [1:0]            occ;
    logic [AXI_ADDR_W-1:0] step;
    logic [AXI_ADDR_W-1:0] wrap_mask;
    logic [AXI_ADDR_W-1:0] addr_inc;
    logic [AXI_ADDR_W-1:0] addr_next;
    logic [1:0]            fifo_count;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  r_hs;
    rbeat_t                pend_beat;
    rbeat_t                fifo_dout;
    rbeat_t                out_beat;

    always_comb begin
        if (ARLEN_IS_COUNT) begin
            beats_req = (arlen == 8'd0) ? 9'd1 : {1'b0, arlen};
        end else begin
            beats_req = {1'b0, arlen} + 9'd1;
        end
        bad_req = (arsize > 3'd3) || (arburst == 2'b11) ||
                  ((arburst == BURST_WRAP) &&
                   !((beats_req == 9'd2) || (beats_req == 9'd4) ||
                     (beats_req == 9'd8) || (beats_req == 9'd16)));
    end

    assign ar_hs = arvalid & arready_q;

    // Illegal requests still walk the address as INCR so every beat gets a slot.
    assign step      = 32'd1 << size_q;
    assign wrap_mask = ({23'd0, beats_q} << size_q) - 32'd1;
    assign addr_inc  = addr_q + step;

    always_comb begin
        case (mode_q)
            BURST_FIXED: addr_next = addr_q;
            BURST_WRAP:  addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
            default:     addr_next = addr_inc;
        endcase
    end

    // Unsigned offset compare also rejects addresses below MEM_BASE via wraparound.
    assign in_range  = (addr_q - MEM_BASE) < MEM_BYTES;
    assign beat_resp = !in_range ? RESP_DECERR : (slverr_q ? RESP_SLVERR : RESP_OKAY);
    assign occ       = fifo_count + {1'b0, pend_vld_q};

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ar_hs) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                issue = (issue_left_q != 9'd0) && (occ < 2'd2);
                if (issue && (issue_left_q == 9'd1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_hs && out_beat.last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_en   = issue & in_range;
    assign mem_addr = mem_en ? {addr_q[AXI_ADDR_W-1:3], 3'b000} : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            arready_q    <= 1'b0;
            addr_q       <= '0;
            mode_q       <= BURST_INCR;
            size_q       <= 3'd0;
            beats_q      <= 9'd0;
            slverr_q     <= 1'b0;
            issue_left_q <= 9'd0;
            pend_vld_q   <= 1'b0;
            pend_resp_q  <= RESP_OKAY;
            pend_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            arready_q   <= (state_d == ST_IDLE);
            pend_vld_q  <= issue;
            pend_resp_q <= beat_resp;
            pend_last_q <= (issue_left_q == 9'd1);
            if (ar_hs) begin
                addr_q       <= araddr;
                mode_q       <= bad_req ? BURST_INCR : arburst;
                size_q       <= arsize;
                beats_q      <= beats_req;
                slverr_q     <= bad_req;
                issue_left_q <= beats_req;
            end else if (issue) begin
                addr_q       <= addr_next;
                issue_left_q <= issue_left_q - 9'd1;
            end
        end
    end

    // Memory return bypasses the buffer when it is empty, giving rvalid 2 cycles after AR.
    always_comb begin
        pend_beat.data = (pend_resp_q == RESP_DECERR) ? '0 : mem_rdata;
        pend_beat.resp = pend_resp_q;
        pend_beat.last = pend_last_q;
    end

    assign fifo_empty = (fifo_count == 2'd0);
    assign rvalid     = !fifo_empty | pend_vld_q;
    assign out_beat   = fifo_empty ? pend_beat : fifo_dout;
    assign r_hs       = rvalid & rready;
    assign fifo_pop   = !fifo_empty & rready;
    assign fifo_push  = pend_vld_q & !(fifo_empty & rready);

    axi_rd_skid_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (pend_beat),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign arready = arready_q;
    assign rdata   = rvalid ? out_beat.data : '0;
    assign rresp   = rvalid ? out_beat.resp : RESP_OKAY;
    assign rlast   = rvalid & out_beat.last;

endmodule

// File: tb/tb_axi_burst_rd_slave.sv
// Scoreboard bench: directed bursts push expected beats/addresses, a negedge monitor pops and compares.
module tb_axi_burst_rd_slave;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic [1:0]  arburst = 2'b01;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'd3;
    logic        rready;
    logic [63:0] mem_rdata = '0;
    logic        sel = 1'b0;

    logic        arready0, rvalid0, rlast0, mem_en0, arready1, rvalid1, rlast1, mem_en1;
    logic [63:0] rdata0, rdata1;
    logic [1:0]  rresp0, rresp1;
    logic [31:0] mem_addr0, mem_addr1;
    logic        arvalid0, arvalid1;

    always #5 clk = ~clk;

    assign arvalid0 = arvalid & !sel;
    assign arvalid1 = arvalid & sel;

    axi_burst_rd_slave u_dut0 (
        .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid0), .arburst(arburst),
        .arlen(arlen), .arsize(arsize), .arready(arready0), .rdata(rdata0), .rresp(rresp0),
        .rvalid(rvalid0), .rlast(rlast0), .rready(rready), .mem_en(mem_en0),
        .mem_addr(mem_addr0), .mem_rdata(mem_rdata)
    );

    axi_burst_rd_slave #(.ARLEN_IS_COUNT(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid1), .arburst(arburst),
        .arlen(arlen), .arsize(arsize), .arready(arready1), .rdata(rdata1), .rresp(rresp1),
        .rvalid(rvalid1), .rlast(rlast1), .rready(rready), .mem_en(mem_en1),
        .mem_addr(mem_addr1), .mem_rdata(mem_rdata)
    );

    wire        arready_m  = sel ? arready1  : arready0;
    wire        rvalid_m   = sel ? rvalid1   : rvalid0;
    wire        rlast_m    = sel ? rlast1    : rlast0;
    wire [63:0] rdata_m    = sel ? rdata1    : rdata0;
    wire [1:0]  rresp_m    = sel ? rresp1    : rresp0;
    wire        mem_en_m   = sel ? mem_en1   : mem_en0;
    wire [31:0] mem_addr_m = sel ? mem_addr1 : mem_addr0;

    // Synchronous memory: data for an address appears the cycle after mem_en.
    always @(posedge clk) begin
        mem_rdata <= mem_en_m ? {mem_addr_m ^ 32'hA5A5_A5A5, mem_addr_m} : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] maddr_q[$];
    int          checks = 0;
    int          errors = 0;
    int          rr_mode = 0;
    int          pat_i = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [1:0] resp, input logic last);
        exp_t        e;
        logic [31:0] al;
        al     = {a[31:3], 3'b000};
        e.data = (resp == RESP_DECERR) ? 64'd0 : {al ^ 32'hA5A5_A5A5, al};
        e.resp = resp;
        e.last = last;
        exp_q.push_back(e);
        if (resp != RESP_DECERR) maddr_q.push_back(al);
    endtask

    initial begin
        rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rr_mode == 1) begin
                rready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
                pat_i++;
            end else begin
                rready = 1'b1;
            end
        end
    end

    logic        stall_prev = 1'b0;
    logic [66:0] stall_val = '0;

    always @(negedge clk) begin
        if (!rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) chk("r_stable", {rvalid_m, rdata_m, rresp_m, rlast_m}, {1'b1, stall_val});
            if (mem_en_m) begin
                if (maddr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_en_unexpected: got addr %0h expected no read", mem_addr_m);
                end else begin
                    chk("mem_addr", mem_addr_m, maddr_q.pop_front());
                end
            end
            if (rvalid_m && rready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat_unexpected: got rdata %0h expected no beat", rdata_m);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rdata", rdata_m, e.data);
                    chk("rresp", rresp_m, e.resp);
                    chk("rlast", rlast_m, e.last);
                end
            end
            stall_prev = rvalid_m && !rready;
            stall_val  = {rdata_m, rresp_m, rlast_m};
        end
    end

    task automatic do_burst(input logic [31:0] a, input logic [1:0] b, input logic [7:0] l,
                            input logic [2:0] s, input int nbeats, input int abort_after,
                            input bit lat_chk);
        int cyc;
        int hs;
        int w;
        hs = 0;
        w  = 0;
        @(posedge clk); #1;
        araddr = a; arburst = b; arlen = l; arsize = s; arvalid = 1'b1;
        @(negedge clk);
        while (!arready_m && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!arready_m) begin
            $display("FAIL ar_timeout: got arready 0 expected 1");
            $fatal(1, "arready never asserted");
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        cyc = 1;
        chk("arready_drop", arready_m, 1'b0);
        if (lat_chk) chk("mem_en_latency", mem_en_m, 1'b1);
        while (cyc < 300) begin
            if (lat_chk && cyc == 2) chk("rvalid_latency", rvalid_m, 1'b1);
            if (rvalid_m && rready) begin
                hs++;
                if (abort_after > 0 && hs == abort_after) begin
                    @(posedge clk); #2;
                    rst = 1'b0;
                    #1;
                    chk("reset_outputs", {arready_m, rvalid_m, rlast_m, rresp_m, rdata_m, mem_en_m, mem_addr_m}, '0);
                    exp_q.delete();
                    maddr_q.delete();
                    return;
                end
                if (rlast_m) break;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 300) begin
            checks++; errors++;
            $display("FAIL burst_timeout: got %0d beats expected %0d", hs, nbeats);
        end
        chk("beat_count", hs, nbeats);
        if (rr_mode == 0) chk("stream_cycles", cyc, nbeats + 1);
        @(negedge clk);
        chk("arready_after", arready_m, 1'b1);
        chk("scoreboard_left", exp_q.size() + maddr_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_state", {arready_m, rvalid_m, rlast_m, rresp_m, rdata_m, mem_en_m, mem_addr_m}, '0);
        rst = 1'b1;
        @(negedge clk);
        chk("arready_post_reset", arready_m, 1'b1);

        for (int i = 0; i < 8; i++) push_exp(32'h8000_0040 + 32'(8 * i), RESP_OKAY, i == 7);
        do_burst(32'h8000_0040, BURST_INCR, 8'd8, 3'd3, 8, 0, 1'b1);

        rr_mode = 1;
        for (int i = 0; i < 8; i++) push_exp(32'h8000_0040 + 32'(8 * i), RESP_OKAY, i == 7);
        do_burst(32'h8000_0040, BURST_INCR, 8'd8, 3'd3, 8, 0, 1'b1);
        rr_mode = 0;

        push_exp(32'h8000_0030, RESP_OKAY, 1'b0);
        push_exp(32'h8000_0038, RESP_OKAY, 1'b0);
        push_exp(32'h8000_0020, RESP_OKAY, 1'b0);
        push_exp(32'h8000_0028, RESP_OKAY, 1'b1);
        do_burst(32'h8000_0030, BURST_WRAP, 8'd4, 3'd3, 4, 0, 1'b1);

        push_exp(32'h7FFF_FFF8, RESP_DECERR, 1'b0);
        push_exp(32'h8000_0000, RESP_OKAY, 1'b1);
        do_burst(32'h7FFF_FFF8, BURST_INCR, 8'd2, 3'd3, 2, 0, 1'b0);

        push_exp(32'h8000_0000, RESP_SLVERR, 1'b0);
        push_exp(32'h8000_0010, RESP_SLVERR, 1'b1);
        do_burst(32'h8000_0000, BURST_INCR, 8'd2, 3'd4, 2, 0, 1'b1);

        push_exp(32'h8000_0030, RESP_SLVERR, 1'b0);
        push_exp(32'h8000_0038, RESP_SLVERR, 1'b0);
        push_exp(32'h8000_0040, RESP_SLVERR, 1'b1);
        do_burst(32'h8000_0030, BURST_WRAP, 8'd3, 3'd3, 3, 0, 1'b1);

        push_exp(32'h8000_0100, RESP_OKAY, 1'b1);
        do_burst(32'h8000_0100, BURST_INCR, 8'd0, 3'd3, 1, 0, 1'b1);

        push_exp(32'h8000_0008, RESP_OKAY, 1'b0);
        push_exp(32'h8000_0008, RESP_OKAY, 1'b0);
        push_exp(32'h8000_0008, RESP_OKAY, 1'b1);
        do_burst(32'h8000_0008, BURST_FIXED, 8'd3, 3'd3, 3, 0, 1'b1);

        sel = 1'b1;
        for (int i = 0; i < 8; i++) push_exp(32'h8000_0200 + 32'(8 * i), RESP_OKAY, i == 7);
        do_burst(32'h8000_0200, BURST_INCR, 8'd7, 3'd3, 8, 0, 1'b1);
        sel = 1'b0;

        for (int i = 0; i < 8; i++) push_exp(32'h8000_0040 + 32'(8 * i), RESP_OKAY, i == 7);
        do_burst(32'h8000_0040, BURST_INCR, 8'd8, 3'd3, 8, 3, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arready_after_abort", arready_m, 1'b1);

        for (int i = 0; i < 4; i++) push_exp(32'h8000_0080 + 32'(8 * i), RESP_OKAY, i == 3);
        do_burst(32'h8000_0080, BURST_INCR, 8'd4, 3'd3, 4, 0, 1'b1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_burst_rd_slave.md
Name: axi_burst_rd_slave

Overview:
- AXI4 read-channel responder (AR + R only) that serves burst reads from a synchronous 64-bit memory read port.
- Sits on the memory side of the instruction-fetch bus, answering the icache line-fill bursts (INCR, arsize=3, 8 beats) and any other read master on the same bus.
- Handles one burst at a time.
- Absorbs R-channel backpressure with a 2-entry output buffer, so it sustains 1 beat/cycle while rready stays high.

Parameters:
- MEM_BASE, 32'h8000_0000, first byte address served.
- MEM_BYTES, 32'h0800_0000, size of the served window in bytes.
- ARLEN_IS_COUNT, 1, 1: beats = arlen (arlen=0 treated as 1 beat), the bus convention used by the icache; 0: AXI-standard beats = arlen+1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- araddr  in  32  burst start byte address
- arvalid  in  1  AR valid
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- arlen  in  8  burst length field (see ARLEN_IS_COUNT)
- arsize  in  3  log2 bytes per beat
- arready  out  1  AR ready
- rdata  out  64  read data
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- rvalid  out  1  R valid
- rlast  out  1  last beat of burst
- rready  in  1  R ready
- mem_en  out  1  memory read strobe
- mem_addr  out  32  memory byte address, bits[2:0] forced to 0
- mem_rdata  in  64  memory data, valid exactly 1 cycle after mem_en

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 (arready, rvalid, rlast, rresp, rdata, mem_en, mem_addr); buffer emptied; beat counters cleared.
- arready is registered: it is 1 in IDLE from the first clock after reset release.
- Reset mid-burst aborts the burst; any pending mem_rdata is discarded.
- States:
  - IDLE: arready=1. On arvalid&arready, latch addr/burst/size/beat count and go to ISSUE; arready drops the next cycle.
  - ISSUE: assert mem_en for the current beat when (buffer entries + reads in flight) < 2 and beats remain to issue. After the last issue, go to DRAIN.
  - DRAIN: wait until the buffer is empty and the last beat has handshaked, then return to IDLE.
  - ISSUE may pass directly to IDLE when the last handshake coincides.
- Latency: AR handshake at edge T → mem_en high in cycle T+1 → rvalid high in cycle T+2 (rdata = mem_rdata).
  - With rready held at 1, beats stream 1 per cycle with no bubbles.
  - After the last R handshake, arready is 1 in the next cycle.
- R channel rules:
  - rvalid, rdata, rresp and rlast hold stable while rvalid & !rready.
  - rlast=1 only on the final beat.
  - rvalid never depends combinationally on rready.
- Buffer: 2-entry FIFO. A write (mem data return) and a read (R handshake) in the same cycle leave the count unchanged. The issue throttle guarantees it never overflows.
- Address generation (step = 1<<arsize):
  - INCR: address advances by step each beat.
  - FIXED: address is constant.
  - WRAP: legal only for beats in {2,4,8,16}; the address wraps inside the aligned (beats*step) region.
  - mem_addr is the beat address with bits[2:0] cleared. Address arithmetic is 32-bit and wraps modulo 2^32.
- Responses, per beat, checked in priority order:
  - Beat address outside [MEM_BASE, MEM_BASE+MEM_BYTES) → DECERR, rdata=0, no mem_en for that beat, but the beat still occupies its slot.
  - arsize>3, arburst=11, or WRAP with an illegal length → SLVERR on every beat; the address advances as INCR; memory data is returned.
  - Otherwise → OKAY.
- The requested number of beats is always returned, whatever the response, and rlast always terminates the burst.

Decomposition:
- Shared package axi_pkg:
  - burst encodings: BURST_FIXED, BURST_INCR, BURST_WRAP
  - response encodings: RESP_OKAY, RESP_SLVERR, RESP_DECERR
  - AXI_DATA_W=64, AXI_ADDR_W=32
- One natural sub-module: axi_rd_skid_fifo, a 2-entry FIFO of {rdata, rresp, rlast} with count output.
- Address/beat generation stays in the top module.

Test Plan:
- Icache fill: araddr=0x8000_0040, INCR, arlen=8, arsize=3, rready=1 → arready drops after handshake; mem_addr 0x40..0x78 in steps of 8 on consecutive cycles; 8 beats back-to-back, rresp=00, rlast only on beat 8; arready=1 the cycle after.
- Backpressure: same burst with rready toggled 1,0,0,1,... → no beat lost or duplicated; rdata stays stable during stalls; mem_en pauses whenever buffer plus in-flight reads reach 2.
- WRAP: araddr=0x8000_0030, WRAP, 4 beats, arsize=3 → addresses 0x30, 0x38, 0x20, 0x28, all OKAY.
- Errors:
  - araddr=0x7FFF_FFF8, INCR, 2 beats → beat1 DECERR with rdata=0 and no mem_en; beat2 (0x8000_0000) OKAY.
  - arsize=4 → SLVERR on all beats.
- ARLEN_IS_COUNT:
  - =1 with arlen=0 → exactly 1 beat with rlast=1.
  - =0 with arlen=7 → 8 beats.
- Reset mid-burst: rst low after beat 3 of 8 → all outputs 0 immediately; after release, arready=1 and a fresh burst completes correctly.
